// File: rtl/timer_set_ctrl.sv
// timer_set_ctrl: seconds prescaler and hour/minute setting sequencer for seven_seg_timer
// Ports: clk, reset (sync, active-high); btn_mode/btn_inc/btn_cancel one-cycle button pulses;
//   cur_hour/cur_min live timer value; sec_tick one-cycle advance pulse; load/load_hour/load_min
//   commit strobe and value; blink_hour/blink_min digit blanking; mode = 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 COMMIT
module timer_set_ctrl #(
   parameter int CLK_DIV   = 2,
   parameter int BLINK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_cancel,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       sec_tick,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic       blink_hour,
   output logic       blink_min,
   output logic [1:0] mode
);
   localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [4:0]    sh_hour_q, sh_hour_d, load_hour_q, load_hour_d;
   logic [5:0]    sh_min_q, sh_min_d, load_min_q, load_min_d;
   logic          phase_q, phase_d, tick_q, tick_d, load_q, load_d;
   logic          blink_hour_q, blink_hour_d, blink_min_q, blink_min_d;
   logic          p_wrap, b_wrap, in_set;
   assign p_wrap = presc_q == PW'(CLK_DIV - 1);
   assign b_wrap = bcnt_q == BW'(BLINK_DIV - 1);
   always_comb begin
      state_d   = state_q;
      sh_hour_d = sh_hour_q;
      sh_min_d  = sh_min_q;
      presc_d   = '0;
      tick_d    = 1'b0;
      case (state_q)
         RUN:
            if (btn_mode) begin
               state_d   = SET_HOUR;
               sh_hour_d = cur_hour > 5'd23 ? '0 : cur_hour;
               sh_min_d  = cur_min > 6'd59 ? '0 : cur_min;
            end else begin
               presc_d = p_wrap ? '0 : presc_q + 1'b1;
               tick_d  = p_wrap;
            end
         SET_HOUR:
            if (btn_cancel) state_d = RUN;
            else if (btn_mode) state_d = SET_MIN;
            else if (btn_inc) sh_hour_d = sh_hour_q == 5'd23 ? '0 : sh_hour_q + 5'd1;
         SET_MIN:
            if (btn_cancel) state_d = RUN;
            else if (btn_mode) state_d = COMMIT;
            else if (btn_inc) sh_min_d = sh_min_q == 6'd59 ? '0 : sh_min_q + 6'd1;
         default: state_d = RUN;
      endcase
      // blink timing restarts from phase 0 on any state change
      in_set       = (state_q == SET_HOUR || state_q == SET_MIN) && state_d == state_q;
      bcnt_d       = in_set && !b_wrap ? bcnt_q + 1'b1 : '0;
      phase_d      = in_set && (phase_q ^ b_wrap);
      load_d       = state_d == COMMIT;
      load_hour_d  = load_d ? sh_hour_d : load_hour_q;
      load_min_d   = load_d ? sh_min_d : load_min_q;
      blink_hour_d = state_d == SET_HOUR && phase_d;
      blink_min_d  = state_d == SET_MIN && phase_d;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         presc_q      <= '0;
         bcnt_q       <= '0;
         phase_q      <= 1'b0;
         sh_hour_q    <= '0;
         sh_min_q     <= '0;
         tick_q       <= 1'b0;
         load_q       <= 1'b0;
         load_hour_q  <= '0;
         load_min_q   <= '0;
         blink_hour_q <= 1'b0;
         blink_min_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         bcnt_q       <= bcnt_d;
         phase_q      <= phase_d;
         sh_hour_q    <= sh_hour_d;
         sh_min_q     <= sh_min_d;
         tick_q       <= tick_d;
         load_q       <= load_d;
         load_hour_q  <= load_hour_d;
         load_min_q   <= load_min_d;
         blink_hour_q <= blink_hour_d;
         blink_min_q  <= blink_min_d;
      end
   end
   assign sec_tick   = tick_q;
   assign load       = load_q;
   assign load_hour  = load_hour_q;
   assign load_min   = load_min_q;
   assign blink_hour = blink_hour_q;
   assign blink_min  = blink_min_q;
   assign mode       = state_q;
endmodule

// File: tb/tb_timer_set_ctrl.sv
// tb_timer_set_ctrl: directed scoreboard bench for timer_set_ctrl
module tb_timer_set_ctrl;
   localparam int CLK_DIV = 2;
   typedef struct {
      int         e;
      logic [4:0] h;
      logic [5:0] m;
   } ld_t;
   logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min = '0;
   logic       sec_tick, load, blink_hour, blink_min;
   logic [4:0] load_hour;
   logic [5:0] load_min;
   logic [1:0] mode;
   ld_t        lq[$];
   int         tq[$];
   int         edge_n = 0, run_start = 0, n_chk = 0, n_fail = 0;
   logic [1:0] prev_m = 2'd0;
   logic [4:0] eh = '0;
   logic [5:0] em = '0;
   logic       te, le;

   timer_set_ctrl #(.CLK_DIV(CLK_DIV), .BLINK_DIV(4)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_cancel(btn_cancel),
      .cur_hour(cur_hour), .cur_min(cur_min), .sec_tick(sec_tick), .load(load),
      .load_hour(load_hour), .load_min(load_min), .blink_hour(blink_hour), .blink_min(blink_min),
      .mode(mode)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d want %0d", nm, edge_n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      te = tq.size() > 0 && tq[0] == edge_n;
      le = lq.size() > 0 && lq[0].e == edge_n;
      check("sec_tick", int'(sec_tick), int'(te));
      check("load", int'(load), int'(le));
      if (le) begin
         check("load_hour", int'(load_hour), int'(lq[0].h));
         check("load_min", int'(load_min), int'(lq[0].m));
         void'(lq.pop_front());
      end
      if (te) void'(tq.pop_front());
   end

   task automatic step(input logic r, input logic bm, input logic bi, input logic bc, input logic [1:0] m_exp);
      int  e;
      ld_t x;
      reset = r;
      btn_mode = bm;
      btn_inc = bi;
      btn_cancel = bc;
      @(posedge clk);
      #1;
      reset = 1'b0;
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      btn_cancel = 1'b0;
      e = edge_n;
      if (r || (prev_m != 2'd0 && m_exp == 2'd0)) run_start = e;
      else if (prev_m == 2'd0 && m_exp == 2'd0 && (e - run_start) % CLK_DIV == 0) tq.push_back(e);
      if (m_exp == 2'd3) begin
         x.e = e;
         x.h = eh;
         x.m = em;
         lq.push_back(x);
      end
      check("mode", int'(mode), int'(m_exp));
      prev_m = m_exp;
   endtask

   task automatic idle(input int n, input logic [1:0] m);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, m);
   endtask

   task automatic chk_zero(input string nm);
      check({nm, "_sec_tick"}, int'(sec_tick), 0);
      check({nm, "_load"}, int'(load), 0);
      check({nm, "_load_hour"}, int'(load_hour), 0);
      check({nm, "_load_min"}, int'(load_min), 0);
      check({nm, "_blink_hour"}, int'(blink_hour), 0);
      check({nm, "_blink_min"}, int'(blink_min), 0);
      check({nm, "_mode"}, int'(mode), 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk_zero("reset");
      idle(20, 0);
      cur_hour = 5'd23;
      cur_min = 6'd59;
      step(0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 2);
      step(0, 0, 1, 0, 2);
      eh = 5'd0;
      em = 6'd0;
      step(0, 1, 0, 0, 3);
      step(0, 1, 1, 1, 0);
      idle(4, 0);
      cur_hour = 5'd10;
      cur_min = 6'd0;
      step(0, 1, 0, 0, 1);
      repeat (30) step(0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 2);
      repeat (61) step(0, 0, 1, 0, 2);
      eh = 5'd16;
      em = 6'd1;
      step(0, 1, 0, 0, 3);
      idle(3, 0);
      check("load_hour_hold", int'(load_hour), 16);
      check("load_min_hold", int'(load_min), 1);
      cur_hour = 5'd5;
      cur_min = 6'd7;
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 2);
      step(0, 0, 1, 0, 2);
      eh = 5'd5;
      em = 6'd8;
      step(0, 1, 1, 0, 3);
      idle(2, 0);
      step(0, 1, 0, 0, 1);
      step(0, 0, 1, 1, 0);
      idle(3, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      idle(3, 0);
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 2);
      step(0, 1, 0, 1, 0);
      idle(5, 0);
      step(0, 1, 0, 0, 1);
      check("blink_hour_entry", int'(blink_hour), 0);
      check("blink_min_entry", int'(blink_min), 0);
      for (int j = 1; j <= 13; j++) begin
         step(0, 0, 0, 0, 1);
         check("blink_hour", int'(blink_hour), (j / 4) % 2);
         check("blink_min_in_hour", int'(blink_min), 0);
      end
      step(0, 1, 0, 0, 2);
      check("blink_hour_leave", int'(blink_hour), 0);
      check("blink_min_entry2", int'(blink_min), 0);
      for (int j = 1; j <= 5; j++) begin
         step(0, 0, 0, 0, 2);
         check("blink_min", int'(blink_min), (j / 4) % 2);
         check("blink_hour_in_min", int'(blink_hour), 0);
      end
      step(0, 0, 0, 1, 0);
      check("blink_min_cancel", int'(blink_min), 0);
      idle(2, 0);
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 2);
      step(0, 0, 1, 0, 2);
      step(1, 0, 0, 0, 0);
      chk_zero("rst_set_min");
      idle(4, 0);
      cur_hour = 5'd31;
      cur_min = 6'd63;
      step(0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 2);
      step(0, 0, 1, 0, 2);
      eh = 5'd2;
      em = 6'd1;
      step(0, 1, 0, 0, 3);
      step(1, 0, 0, 0, 0);
      chk_zero("rst_commit");
      idle(6, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
